// File: rtl/gray_cipher_pipe.sv
// ============================================================================
// Module   : gray_cipher_pipe
// Purpose  : Two-stage valid/ready pipeline implementing the one-hot <-> gray
//            cipher.
//            Encrypt: a one-hot word becomes (cipher, private key).
//            Decrypt: (cipher, private key) becomes the one-hot word.
//            Each transaction uses the public key held at the moment it is
//            accepted. Malformed inputs are flagged but still processed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_cipher_pipe #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_wr,
  input  logic [W-1:0]        key_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [(1<<W)-1:0]   in_onehot,
  input  logic [W-1:0]        in_cipher,
  input  logic [W-1:0]        in_prv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_mode,
  output logic [W-1:0]        out_cipher,
  output logic [W-1:0]        out_prv,
  output logic [(1<<W)-1:0]   out_onehot,
  output logic                out_err
);

  localparam int OHW = 1 << W;

  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [W-1:0] f_hi_idx(input logic [OHW-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < OHW; i++) begin
      if (v[i]) r = i[W-1:0];
    end
    return r;
  endfunction

  // Thermometer private key: bit k is set when popcount(g) >= k+1.
  function automatic logic [W-1:0] f_thresh(input logic [W-1:0] g);
    int cnt;
    logic [W-1:0] p;
    cnt = 0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + int'(g[i]);
    end
    for (int k = 0; k < W; k++) begin
      p[k] = (cnt > k);
    end
    return p;
  endfunction

  // Gray code to binary, MSB first.
  function automatic logic [W-1:0] f_gray2bin(input logic [W-1:0] g);
    logic [W-1:0] n;
    n[W-1] = g[W-1];
    for (int k = W - 2; k >= 0; k--) begin
      n[k] = n[k+1] ^ g[k];
    end
    return n;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [W-1:0]   pub_q;

  // S1 holds the index b (encrypt) or the recovered gray code g (decrypt)
  // in one shared field, selected by s1_mode_q.
  logic           s1_valid_q, s1_valid_d;
  logic           s1_mode_q,  s1_mode_d;
  logic           s1_err_q,   s1_err_d;
  logic [W-1:0]   s1_val_q,   s1_val_d;
  logic [W-1:0]   s1_pub_q,   s1_pub_d;

  logic           s2_valid_q, s2_valid_d;
  logic           s2_mode_q,  s2_mode_d;
  logic           s2_err_q,   s2_err_d;
  logic [W-1:0]   s2_cipher_q, s2_cipher_d;
  logic [W-1:0]   s2_prv_q,    s2_prv_d;
  logic [OHW-1:0] s2_onehot_q, s2_onehot_d;

  logic           w_s1_adv;
  logic           w_accept;

  // --------------------------------------------------------------------------
  // Flow control: S1 may move into S2 whenever S2 is empty or draining.
  // --------------------------------------------------------------------------
  assign w_s1_adv = !s2_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || w_s1_adv);
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Stage 1 next state: index / error for encrypt, gray recovery for decrypt.
  // --------------------------------------------------------------------------
  logic [W-1:0] w_enc_b;
  logic         w_enc_err;
  logic [W-1:0] w_dec_g;
  logic         w_dec_err;

  // Stage-1 datapath and register next-state selection.
  always_comb begin
    w_enc_b    = f_hi_idx(in_onehot);
    // Exactly one bit set <=> nonzero and clearing the lowest bit leaves zero.
    w_enc_err  = (in_onehot == '0) || ((in_onehot & (in_onehot - 1'b1)) != '0);
    w_dec_g    = in_cipher ^ pub_q ^ in_prv;
    w_dec_err  = (in_prv != f_thresh(w_dec_g));

    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_err_d   = s1_err_q;
    s1_val_d   = s1_val_q;
    s1_pub_d   = s1_pub_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (w_accept) begin
      s1_mode_d = in_mode;
      s1_err_d  = in_mode ? w_dec_err : w_enc_err;
      s1_val_d  = in_mode ? w_dec_g   : w_enc_b;
      s1_pub_d  = pub_q;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 next state: cipher/key generation or one-hot reconstruction.
  // --------------------------------------------------------------------------
  logic [W-1:0]   w_enc_n;
  logic [W-1:0]   w_enc_g;
  logic [W-1:0]   w_enc_p;
  logic [W-1:0]   w_dec_b;
  logic [OHW-1:0] w_dec_oh;

  // Stage-2 datapath; results of the unused mode are forced to zero.
  always_comb begin
    w_enc_n  = ~s1_val_q;
    w_enc_g  = w_enc_n ^ (w_enc_n >> 1);
    w_enc_p  = f_thresh(w_enc_g);
    w_dec_b  = ~f_gray2bin(s1_val_q);
    w_dec_oh = {{(OHW-1){1'b0}}, 1'b1} << w_dec_b;

    s2_valid_d  = s2_valid_q;
    s2_mode_d   = s2_mode_q;
    s2_err_d    = s2_err_q;
    s2_cipher_d = s2_cipher_q;
    s2_prv_d    = s2_prv_q;
    s2_onehot_d = s2_onehot_q;

    if (w_s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d   = s1_mode_q;
        s2_err_d    = s1_err_q;
        s2_cipher_d = s1_mode_q ? '0 : (w_enc_g ^ w_enc_p ^ s1_pub_q);
        s2_prv_d    = s1_mode_q ? '0 : w_enc_p;
        s2_onehot_d = s1_mode_q ? w_dec_oh : '0;
      end
    end
  end

  // Public key register; an accept in the same cycle still sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pub_q <= '0;
    end else if (key_wr) begin
      pub_q <= key_in;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_val_q   <= '0;
      s1_pub_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_err_q   <= s1_err_d;
      s1_val_q   <= s1_val_d;
      s1_pub_q   <= s1_pub_d;
    end
  end

  // Stage-2 (output) registers; they hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_cipher_q <= '0;
      s2_prv_q    <= '0;
      s2_onehot_q <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_err_q    <= s2_err_d;
      s2_cipher_q <= s2_cipher_d;
      s2_prv_q    <= s2_prv_d;
      s2_onehot_q <= s2_onehot_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_mode   = s2_mode_q;
  assign out_err    = s2_err_q;
  assign out_cipher = s2_cipher_q;
  assign out_prv    = s2_prv_q;
  assign out_onehot = s2_onehot_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_cipher_pipe.sv
// ============================================================================
// Module   : tb_gray_cipher_pipe
// Purpose  : Scoreboard testbench for gray_cipher_pipe (W = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_cipher_pipe;

  localparam int W = 4;

  typedef struct packed {
    logic        mode;
    logic [3:0]  cipher;
    logic [3:0]  prv;
    logic [15:0] onehot;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_wr = 1'b0;
  logic [3:0]  key_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [15:0] in_onehot = '0;
  logic [3:0]  in_cipher = '0;
  logic [3:0]  in_prv = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_mode;
  logic [3:0]  out_cipher;
  logic [3:0]  out_prv;
  logic [15:0] out_onehot;
  logic        out_err;

  int   tests = 0;
  int   fails = 0;
  int   n_in  = 0;
  int   n_out = 0;
  bit   rand_rdy = 1'b0;
  logic [3:0] pub_m = '0;
  exp_t q[$];

  gray_cipher_pipe #(.W(W)) dut (
    .clk(clk), .rst(rst), .key_wr(key_wr), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_onehot(in_onehot), .in_cipher(in_cipher), .in_prv(in_prv),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_cipher(out_cipher), .out_prv(out_prv), .out_onehot(out_onehot),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference model written from the cipher rules with plain arithmetic.
  function automatic exp_t model(input logic m, input logic [15:0] oh,
                                 input logic [3:0] c, input logic [3:0] pr,
                                 input logic [3:0] pub);
    exp_t e;
    int b, pc;
    logic [3:0] n, g;
    logic [15:0] one16;
    one16 = 16'd1;
    e = '0;
    e.mode = m;
    if (!m) begin
      b = 0;
      for (int i = 0; i < 16; i++) if (oh[i]) b = i;
      n = ~4'(b);
      g = n ^ (n >> 1);
      pc = $countones(g);
      e.prv = 4'((1 << pc) - 1);
      e.cipher = g ^ e.prv ^ pub;
      e.err = ($countones(oh) != 1);
    end else begin
      g = c ^ pub ^ pr;
      pc = $countones(g);
      e.err = (pr != 4'((1 << pc) - 1));
      n = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
      e.onehot = one16 << (~n);
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic m, input logic [3:0] c, input logic [3:0] p,
                              input logic [15:0] oh, input logic err);
    exp_t e;
    e.mode = m; e.cipher = c; e.prv = p; e.onehot = oh; e.err = err;
    return e;
  endfunction

  // Randomised consumer back-pressure.
  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops and compares every delivered result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      n_out++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL result unexpected: got mode=%0b c=%h p=%h oh=%h err=%0b, required none",
                 out_mode, out_cipher, out_prv, out_onehot, out_err);
      end else begin
        e = q.pop_front();
        if (out_mode !== e.mode || out_cipher !== e.cipher || out_prv !== e.prv ||
            out_onehot !== e.onehot || out_err !== e.err) begin
          fails++;
          $display("FAIL result#%0d got mode=%0b c=%h p=%h oh=%h err=%0b, required mode=%0b c=%h p=%h oh=%h err=%0b",
                   n_out, out_mode, out_cipher, out_prv, out_onehot, out_err,
                   e.mode, e.cipher, e.prv, e.onehot, e.err);
        end
      end
    end
  end

  // One clock cycle: check in_ready against occupancy, record an accept.
  task automatic tick(input bit do_push, input exp_t e, output bit acc);
    int occ;
    @(negedge clk);
    #1;
    occ = n_in - n_out + ((out_valid && out_ready) ? 1 : 0);
    tests++;
    if (in_ready !== !(occ == 2 && !out_ready)) begin
      fails++;
      $display("FAIL in_ready got %0b, required %0b (occupancy %0d, out_ready %0b)",
               in_ready, !(occ == 2 && !out_ready), occ, out_ready);
    end
    acc = in_valid && in_ready;
    if (acc && do_push) begin
      q.push_back(e);
      n_in++;
    end
    @(posedge clk);
    if (key_wr) pub_m = key_in;
    #1;
    key_wr = 1'b0;
  endtask

  // Offer one transaction until accepted; returns the expectation used.
  task automatic issue(input logic m, input logic [15:0] oh, input logic [3:0] c,
                       input logic [3:0] pr, input bit kw, input logic [3:0] kv,
                       input bit use_e, input exp_t ed, output exp_t eo);
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_mode = m; in_onehot = oh; in_cipher = c; in_prv = pr;
    key_wr = kw; key_in = kv;
    eo = '0;
    for (int t = 0; t < 200 && !done; t++) begin
      eo = use_e ? ed : model(m, oh, c, pr, pub_m);
      tick(1'b1, eo, acc);
      done = acc;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept timeout: got in_ready=0 for 200 cycles, required accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, acc);
  endtask

  initial begin
    exp_t e, r;
    logic [15:0] oh;

    // Reset state.
    #3;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_mode !== 1'b0 || out_cipher !== '0 ||
        out_prv !== '0 || out_onehot !== '0 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got ov=%0b ir=%0b c=%h p=%h oh=%h err=%0b, required all 0",
               out_valid, in_ready, out_cipher, out_prv, out_onehot, out_err);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    issue(1'b0, 16'h0001, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b0, 4'h9, 4'h1, 16'h0, 1'b0), r);
    issue(1'b1, 16'h0000, 4'h9, 4'h1, 1'b0, 4'h0, 1'b1, mk(1'b1, 4'h0, 4'h0, 16'h0001, 1'b0), r);
    key_wr = 1'b1; key_in = 4'hA; idle(1);
    issue(1'b0, 16'h0020, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b0, 4'hA, 4'hF, 16'h0, 1'b0), r);
    issue(1'b1, 16'h0000, 4'hA, 4'hF, 1'b0, 4'h0, 1'b1, mk(1'b1, 4'h0, 4'h0, 16'h0020, 1'b0), r);
    key_wr = 1'b1; key_in = 4'h0; idle(1);
    issue(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b0, 4'h9, 4'h1, 16'h0, 1'b1), r);
    issue(1'b0, 16'h0006, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b0, 4'hC, 4'h7, 16'h0, 1'b1), r);
    issue(1'b1, 16'h0000, 4'h9, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b1, 4'h0, 4'h0, 16'h0002, 1'b1), r);
    // Highest index: gray code 0, key 0, cipher equals the public key (0).
    issue(1'b0, 16'h8000, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b0, 4'h0, 4'h0, 16'h0, 1'b0), r);
    idle(3);

    // Randomised stream with back-pressure, key writes and round trips.
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      oh = 16'd1 << i;
      issue(1'b0, oh, 4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
            4'($urandom), 1'b0, '0, r);
      issue(1'b1, 16'($urandom), r.cipher, r.prv, 1'b0, 4'h0, 1'b0, '0, e);
      if ($urandom_range(0, 2) == 0)
        issue(1'b1, 16'h0, 4'($urandom), 4'($urandom), 1'b0, 4'h0, 1'b0, '0, e);
      if ($urandom_range(0, 2) == 0)
        issue(1'b0, 16'($urandom), 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, '0, e);
      idle($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    #2;
    out_ready = 1'b1;
    idle(4);

    // Fill the pipe with the consumer stalled, then reset mid-flight.
    out_ready = 1'b0;
    key_wr = 1'b1; key_in = 4'h5; idle(1);
    issue(1'b0, 16'h0004, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, '0, r);
    issue(1'b0, 16'h0010, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, '0, r);
    idle(2);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_midflight got out_valid=%0b in_ready=%0b, required 0 0",
               out_valid, in_ready);
    end
    q.delete();
    n_in = 0; n_out = 0; pub_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Public key back at 0: index 15 gives cipher 0; check 2-cycle latency.
    issue(1'b0, 16'h8000, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b0, 4'h0, 4'h0, 16'h0, 1'b0), r);
    @(negedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_1cycle got out_valid=%0b, required 0", out_valid);
    end
    @(negedge clk); #1;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency_2cycle got out_valid=%0b, required 1", out_valid);
    end
    @(posedge clk); #1;

    // Drain and confirm nothing was lost.
    for (int t = 0; t < 100 && q.size() != 0; t++) idle(1);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d results pending, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_cipher_pipe.md
Name: gray_cipher_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational hex encrypt/decrypt path.
- Encrypt: accepts a one-hot (hexadecimal-select) word and returns cipher data plus the derived private key.
- Decrypt: accepts cipher data plus private key and returns the one-hot word.
- Adds valid/ready flow control, a registered public key, per-transaction key capture, input/consistency error flagging, and arbitrary code width.

Parameters:
- W, 4, binary code width; the one-hot width is 2**W.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- key_wr  in  1  load key_in into the public-key register
- key_in  in  W  new public key
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept this cycle
- in_mode  in  1  0 = encrypt, 1 = decrypt
- in_onehot  in  2**W  encrypt input; ignored when decrypting
- in_cipher  in  W  decrypt cipher input; ignored when encrypting
- in_prv  in  W  decrypt private-key input; ignored when encrypting
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_mode  out  1  mode of the result
- out_cipher  out  W  encrypt result; 0 for decrypt results
- out_prv  out  W  encrypt private key; 0 for decrypt results
- out_onehot  out  2**W  decrypt result; 0 for encrypt results
- out_err  out  1  error flag for this result

Behaviour:
- Reset (async, active-high): pub key = 0, both stage valids = 0, all out_* = 0, in_ready = 0 while rst is high.
- Handshake: a transfer occurs when valid & ready. Two-stage pipeline (S1, S2); latency is 2 cycles from accept to out_valid; throughput is 1 per cycle.
- S1 advances when !S2.valid | out_ready.
- in_ready = !S1.valid | S1 advances; it is combinational from out_ready.
- out_* hold stable while out_valid & !out_ready.
- Public key: key_wr updates the register on the next edge. Each transaction captures the register value at accept. If key_wr and accept occur in the same cycle, the transaction uses the old key. Later key writes never affect in-flight data.
- Encrypt, S1:
  - b = index of the highest set bit of in_onehot (0 if none).
  - err = popcount(in_onehot) != 1.
- Encrypt, S2:
  - n = ~b
  - g = n ^ (n >> 1)
  - p[k] = (popcount(g) >= k+1) for k = 0..W-1
  - out_prv = p
  - out_cipher = g ^ p ^ pub
  - err is carried through unchanged.
- Decrypt, S1:
  - g = in_cipher ^ pub ^ in_prv
  - err = (in_prv != threshold(popcount(g))), using the same p rule as encrypt.
- Decrypt, S2:
  - n = gray-to-binary(g): n[W-1] = g[W-1], n[k] = n[k+1] ^ g[k]
  - b = ~n
  - out_onehot = 1 << b
- On error the result is still computed and delivered; no drop, no stall.
- Round trip: decrypting (out_cipher, out_prv) under the same pub returns the original one-hot word with err = 0.
- Boundaries:
  - b = 2**W-1 gives g = 0, p = 0, cipher = pub.
  - Back-to-back mixed modes are allowed.
  - With out_ready low, the pipeline fills with 2 entries, then in_ready = 0.
- Reset mid-operation: in-flight transactions are discarded, out_valid drops immediately, and pub returns to 0.

Test Plan:
- W=4, pub=0, encrypt 16'h0001 -> after 2 cycles: out_cipher=4'h9, out_prv=4'h1, err=0; decrypt (4'h9, 4'h1) -> out_onehot=16'h0001, err=0.
- key_wr 4'hA, then encrypt 16'h0020 -> out_cipher=4'hA, out_prv=4'hF; decrypt (4'hA, 4'hF) -> 16'h0020.
- Encrypt 16'h0000 -> b=0, err=1, out_cipher=4'h9; encrypt 16'h0006 -> b=2, err=1.
- pub=0, decrypt cipher 4'h9 with prv 4'h0 -> out_onehot=16'h0002, err=1.
- Stream 16 one-hot encrypts with out_ready toggling randomly -> no loss or duplication, order preserved, in_ready=0 exactly when both stages are full and stalled; key_wr in the same cycle as an accept applies to the next transaction only.
- Assert rst with 2 entries in flight -> out_valid=0 and in_ready=0 immediately; after release, pub=0 and the first new result appears 2 cycles after accept.
